sram_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the IF-stage instruction fetch requester and the EX/MEM data requester (the port whose read data feeds MEM's load-extension path).
- Arbitrates requests, locks the grant until the address is accepted, and tracks outstanding transactions in order with an owner FIFO.
- Routes each response to its owner. Instruction responses are discarded after a pipeline flush (exception/ertn cancel).

---
 rtl/sram_port_arbiter_if.sv | 24 ++
 rtl/sram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Requester-style SRAM port bundle: request, address/data fields, and handshake returns.
interface sram_port_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // Side that issues requests (CPU stage, or the arbiter toward memory)
  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Side that accepts requests (the arbiter toward a CPU stage, or memory)
  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access.
// Data has priority, a stalled grant stays locked until accepted, and an
// in-order owner FIFO routes responses back (inst responses dropped on cancel).
module sram_port_arbiter #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_port_arbiter_if.slave   inst,
  sram_port_arbiter_if.slave   data,
  sram_port_arbiter_if.master  m,
  input  logic                 cancel,
  output logic                 busy
);

  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);

  typedef enum logic [1:0] {LK_NONE, LK_INST, LK_DATA} lock_e;

  lock_e                  r_lock;
  lock_e                  w_lock_nxt;
  logic                   w_gnt_inst;
  logic                   w_gnt_data;
  logic                   w_full;
  logic                   w_acc;
  logic                   w_pop;
  logic                   w_head_own;
  logic                   w_head_drop;

  logic [OUTSTANDING-1:0] r_vld;
  logic [OUTSTANDING-1:0] r_own;   // 1 = inst, 0 = data
  logic [OUTSTANDING-1:0] r_drop;
  logic [PW-1:0]          r_wr;
  logic [PW-1:0]          r_rd;
  logic [CW-1:0]          r_cnt;

  // Lock register: remembers which owner holds a stalled grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_lock <= LK_NONE;
    else         r_lock <= w_lock_nxt;
  end

  // Lock next state: hold the granted owner while the port has not accepted;
  // accept or a dropped request naturally falls back to LK_NONE
  always_comb begin
    w_lock_nxt = LK_NONE;
    if (m.req && !m.addr_ok) begin
      if (w_gnt_inst)      w_lock_nxt = LK_INST;
      else if (w_gnt_data) w_lock_nxt = LK_DATA;
    end
  end

  // Grant decode: locked inst first, then data (also covers a data lock), then inst
  always_comb begin
    w_gnt_inst = 1'b0;
    w_gnt_data = 1'b0;
    if (resetn) begin
      if (r_lock == LK_INST && inst.req && !cancel) w_gnt_inst = 1'b1;
      else if (data.req)                            w_gnt_data = 1'b1;
      else if (inst.req && !cancel)                 w_gnt_inst = 1'b1;
    end
  end

  // Downstream request mux and address handshake routing
  always_comb begin
    w_full  = (r_cnt == CW'(OUTSTANDING));
    m.req   = (w_gnt_inst | w_gnt_data) & ~w_full;
    m.wr    = 1'b0;
    m.size  = '0;
    m.addr  = '0;
    m.wstrb = '0;
    m.wdata = '0;
    if (w_gnt_data) begin
      m.wr    = data.wr;
      m.size  = data.size;
      m.addr  = data.addr;
      m.wstrb = data.wstrb;
      m.wdata = data.wdata;
    end else if (w_gnt_inst) begin
      m.wr    = inst.wr;
      m.size  = inst.size;
      m.addr  = inst.addr;
      m.wstrb = inst.wstrb;
      m.wdata = inst.wdata;
    end
    w_acc        = m.req & m.addr_ok;
    inst.addr_ok = w_acc & w_gnt_inst;
    data.addr_ok = w_acc & w_gnt_data;
  end

  // Response routing: pop head, suppress dropped or same-cycle-cancelled inst responses
  always_comb begin
    w_pop        = m.data_ok & (r_cnt != '0);
    w_head_own   = r_own[r_rd];
    w_head_drop  = r_drop[r_rd] | (cancel & w_head_own);
    inst.data_ok = w_pop &  w_head_own & ~w_head_drop;
    data.data_ok = w_pop & ~w_head_own;
    inst.rdata   = inst.data_ok ? m.rdata : '0;
    data.rdata   = data.data_ok ? m.rdata : '0;
    busy         = (r_cnt != '0);
  end

  // Owner FIFO bookkeeping: cancel marking, then pop, then push (push slot never equals pop slot)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld  <= '0;
      r_own  <= '0;
      r_drop <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
    end else begin
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        if (cancel && r_vld[i] && r_own[i]) r_drop[i] <= 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= (r_rd == PW'(OUTSTANDING - 1)) ? '0 : r_rd + PW'(1);
      end
      if (w_acc) begin
        r_vld[r_wr]  <= 1'b1;
        r_own[r_wr]  <= w_gnt_inst;
        r_drop[r_wr] <= 1'b0;
        r_wr         <= (r_wr == PW'(OUTSTANDING - 1)) ? '0 : r_wr + PW'(1);
      end
      case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: priority, lock, full stall, cancel, async reset.
module tb_sram_port_arbiter;

  logic clk;
  logic resetn;
  logic cancel;
  logic busy;

  int unsigned n_vec;
  int unsigned n_err;

  sram_port_arbiter_if u_inst ();
  sram_port_arbiter_if u_data ();
  sram_port_arbiter_if u_m ();

  sram_port_arbiter #(.OUTSTANDING(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (u_inst),
    .data   (u_data),
    .m      (u_m),
    .cancel (cancel),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    u_inst.req = 1'b0; u_inst.wr = 1'b0; u_inst.size = 2'd2; u_inst.addr = '0;
    u_inst.wstrb = '0; u_inst.wdata = '0;
    u_data.req = 1'b0; u_data.wr = 1'b0; u_data.size = 2'd2; u_data.addr = '0;
    u_data.wstrb = '0; u_data.wdata = '0;
    u_m.addr_ok = 1'b0; u_m.data_ok = 1'b0; u_m.rdata = '0;
    cancel = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    resetn = 1'b0;
    #12;
    check_eq("rst_mreq",  {31'd0, u_m.req}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_iaok",  {31'd0, u_inst.addr_ok}, 32'd0);
    check_eq("rst_dok",   {31'd0, u_data.data_ok}, 32'd0);
    tick();
    resetn = 1'b1;

    // Data priority, then inst next cycle, in-order responses
    u_inst.req = 1'b1; u_inst.addr = 32'h1c00_0000;
    u_data.req = 1'b1; u_data.addr = 32'h8000_0010;
    u_m.addr_ok = 1'b1;
    #1;
    check_eq("pri_daok",  {31'd0, u_data.addr_ok}, 32'd1);
    check_eq("pri_iaok",  {31'd0, u_inst.addr_ok}, 32'd0);
    check_eq("pri_maddr", u_m.addr, 32'h8000_0010);
    tick();
    u_data.req = 1'b0;
    #1;
    check_eq("pri_iaok2", {31'd0, u_inst.addr_ok}, 32'd1);
    check_eq("pri_maddr2", u_m.addr, 32'h1c00_0000);
    tick();
    u_inst.req = 1'b0; u_m.addr_ok = 1'b0;
    u_m.data_ok = 1'b1; u_m.rdata = 32'h1111_1111;
    #1;
    check_eq("pri_r1_dok", {31'd0, u_data.data_ok}, 32'd1);
    check_eq("pri_r1_iok", {31'd0, u_inst.data_ok}, 32'd0);
    check_eq("pri_r1_drd", u_data.rdata, 32'h1111_1111);
    tick();
    u_m.rdata = 32'h2222_2222;
    #1;
    check_eq("pri_r2_iok", {31'd0, u_inst.data_ok}, 32'd1);
    check_eq("pri_r2_ird", u_inst.rdata, 32'h2222_2222);
    check_eq("pri_r2_drd", u_data.rdata, 32'h0);
    tick();
    u_m.data_ok = 1'b0;
    #1;
    check_eq("pri_busy0", {31'd0, busy}, 32'd0);

    // Grant lock: inst stalled 3 cycles, data arrives meanwhile
    u_inst.req = 1'b1; u_inst.addr = 32'h1c00_0040;
    #1;
    check_eq("lk_c1_mreq", {31'd0, u_m.req}, 32'd1);
    check_eq("lk_c1_addr", u_m.addr, 32'h1c00_0040);
    tick();
    u_data.req = 1'b1; u_data.addr = 32'h8000_0020;
    #1;
    check_eq("lk_c2_addr", u_m.addr, 32'h1c00_0040);
    check_eq("lk_c2_daok", {31'd0, u_data.addr_ok}, 32'd0);
    tick();
    #1;
    check_eq("lk_c3_addr", u_m.addr, 32'h1c00_0040);
    tick();
    u_m.addr_ok = 1'b1;
    #1;
    check_eq("lk_c4_iaok", {31'd0, u_inst.addr_ok}, 32'd1);
    check_eq("lk_c4_daok", {31'd0, u_data.addr_ok}, 32'd0);
    tick();
    u_inst.req = 1'b0;
    #1;
    check_eq("lk_c5_daok", {31'd0, u_data.addr_ok}, 32'd1);
    check_eq("lk_c5_addr", u_m.addr, 32'h8000_0020);
    tick();
    u_data.req = 1'b0; u_m.addr_ok = 1'b0;
    u_m.data_ok = 1'b1; u_m.rdata = 32'h0000_00aa;
    #1;
    check_eq("lk_r1_iok", {31'd0, u_inst.data_ok}, 32'd1);
    tick();
    u_m.rdata = 32'h0000_00bb;
    #1;
    check_eq("lk_r2_dok", {31'd0, u_data.data_ok}, 32'd1);
    check_eq("lk_r2_drd", u_data.rdata, 32'h0000_00bb);
    tick();
    u_m.data_ok = 1'b0;

    // Full stall: two accepts, third request blocked even with a pop
    u_inst.req = 1'b1; u_inst.addr = 32'h1c00_0100; u_m.addr_ok = 1'b1;
    tick();
    u_inst.req = 1'b0;
    u_data.req = 1'b1; u_data.addr = 32'h8000_0200;
    tick();
    u_data.req = 1'b0;
    u_inst.req = 1'b1; u_inst.addr = 32'h1c00_0104;
    u_m.data_ok = 1'b1; u_m.rdata = 32'h3333_3333;
    #1;
    check_eq("full_mreq",  {31'd0, u_m.req}, 32'd0);
    check_eq("full_iaok",  {31'd0, u_inst.addr_ok}, 32'd0);
    check_eq("full_iok",   {31'd0, u_inst.data_ok}, 32'd1);
    tick();
    u_m.data_ok = 1'b0;
    #1;
    check_eq("full_mreq2", {31'd0, u_m.req}, 32'd1);
    check_eq("full_iaok2", {31'd0, u_inst.addr_ok}, 32'd1);
    tick();
    u_inst.req = 1'b0; u_m.addr_ok = 1'b0;
    u_m.data_ok = 1'b1; u_m.rdata = 32'h4444_4444;
    #1;
    check_eq("full_r_dok", {31'd0, u_data.data_ok}, 32'd1);
    tick();
    u_m.rdata = 32'h5555_5555;
    #1;
    check_eq("full_r_iok", {31'd0, u_inst.data_ok}, 32'd1);
    tick();
    u_m.data_ok = 1'b0;
    #1;
    check_eq("full_busy0", {31'd0, busy}, 32'd0);

    // Cancel drop of an in-flight fetch
    u_inst.req = 1'b1; u_inst.addr = 32'h1c00_0000; u_m.addr_ok = 1'b1;
    tick();
    u_inst.req = 1'b0; u_m.addr_ok = 1'b0;
    cancel = 1'b1;
    #1;
    check_eq("cd_busy", {31'd0, busy}, 32'd1);
    tick();
    cancel = 1'b0;
    u_m.data_ok = 1'b1; u_m.rdata = 32'hdead_beef;
    #1;
    check_eq("cd_iok", {31'd0, u_inst.data_ok}, 32'd0);
    check_eq("cd_ird", u_inst.rdata, 32'h0);
    tick();
    u_m.data_ok = 1'b0;
    u_data.req = 1'b1; u_data.addr = 32'h8000_0100; u_m.addr_ok = 1'b1;
    #1;
    check_eq("cd_daok", {31'd0, u_data.addr_ok}, 32'd1);
    tick();
    u_data.req = 1'b0; u_m.addr_ok = 1'b0;
    u_m.data_ok = 1'b1; u_m.rdata = 32'h1234_5678;
    #1;
    check_eq("cd_dok", {31'd0, u_data.data_ok}, 32'd1);
    check_eq("cd_drd", u_data.rdata, 32'h1234_5678);
    tick();
    u_m.data_ok = 1'b0;

    // Cancel in the same cycle as the inst response; concurrent inst_req blocked
    u_inst.req = 1'b1; u_inst.addr = 32'h1c00_0200; u_m.addr_ok = 1'b1;
    tick();
    cancel = 1'b1; u_m.data_ok = 1'b1; u_m.rdata = 32'h6666_6666;
    u_inst.addr = 32'h1c00_0204;
    #1;
    check_eq("cs_iok",  {31'd0, u_inst.data_ok}, 32'd0);
    check_eq("cs_iaok", {31'd0, u_inst.addr_ok}, 32'd0);
    check_eq("cs_mreq", {31'd0, u_m.req}, 32'd0);
    tick();
    cancel = 1'b0; u_inst.req = 1'b0; u_m.data_ok = 1'b0; u_m.addr_ok = 1'b0;
    #1;
    check_eq("cs_busy0", {31'd0, busy}, 32'd0);

    // Async reset with two entries outstanding
    u_inst.req = 1'b1; u_inst.addr = 32'h1c00_0300; u_m.addr_ok = 1'b1;
    tick();
    u_inst.req = 1'b0;
    u_data.req = 1'b1; u_data.addr = 32'h8000_0300;
    tick();
    u_data.req = 1'b0; u_m.addr_ok = 1'b0;
    #1;
    check_eq("ar_busy1", {31'd0, busy}, 32'd1);
    #2;
    resetn = 1'b0;
    u_inst.req = 1'b1;
    #1;
    check_eq("ar_busy0", {31'd0, busy}, 32'd0);
    check_eq("ar_mreq0", {31'd0, u_m.req}, 32'd0);
    tick();
    u_inst.req = 1'b0;
    resetn = 1'b1;
    u_m.data_ok = 1'b1; u_m.rdata = 32'h7777_7777;
    #1;
    check_eq("ar_iok", {31'd0, u_inst.data_ok}, 32'd0);
    check_eq("ar_dok", {31'd0, u_data.data_ok}, 32'd0);
    tick();
    u_m.data_ok = 1'b0;
    #1;
    check_eq("ar_busy_end", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
